// File: rtl/signed_adder_tree_acc_if.sv
// Bundles the data-path signals of signed_adder_tree_acc.
//   master : drives enable, clear, mode, in_valid and the packed addends,
//            and observes out_valid, sum, sum_delay and overflow.
//   slave  : the adder tree itself (inputs and outputs mirrored).
// The parameters must match the ones given to the attached adder instance.
interface signed_adder_tree_acc_if #(
    parameter int NUM_IN = 8,
    parameter int IN_W   = 8,
    parameter int OUT_W  = 12
);
    logic                           enable;
    logic                           clear;
    logic                           mode;
    logic                           in_valid;
    logic signed [NUM_IN*IN_W-1:0]  addends;
    logic                           out_valid;
    logic signed [OUT_W-1:0]        sum;
    logic signed [OUT_W-1:0]        sum_delay;
    logic                           overflow;

    modport master (
        output enable, clear, mode, in_valid, addends,
        input  out_valid, sum, sum_delay, overflow
    );

    modport slave (
        input  enable, clear, mode, in_valid, addends,
        output out_valid, sum, sum_delay, overflow
    );
endinterface

// File: rtl/signed_adder_tree_acc.sv
// Registered signed adder tree with optional accumulation.
//   clk      : rising-edge clock
//   resetb   : synchronous active-low reset, highest priority
//   bus      : slave side of signed_adder_tree_acc_if
//     enable    1 = run, 0 = zero every register on the next edge
//     clear     zero accumulator/overflow (or restart with this vector)
//     mode      0 = pass-through, 1 = accumulate
//     in_valid  addends valid this cycle
//     addends   NUM_IN packed signed lanes, lane i at [i*IN_W +: IN_W]
//     out_valid sum updated this cycle
//     sum       signed result, saturated (SAT=1) or wrapped (SAT=0)
//     sum_delay sum delayed by DELAY enabled cycles
//     overflow  sticky flag: final stage clipped/wrapped since last clear
// Latency in_valid -> out_valid is ceil(log2(NUM_IN)) + 1 cycles, one
// vector accepted every cycle.
module signed_adder_tree_acc #(
    parameter int NUM_IN = 8,
    parameter int IN_W   = 8,
    parameter int OUT_W  = 12,
    parameter int DELAY  = 1,
    parameter int SAT    = 1
) (
    input logic                   clk,
    input logic                   resetb,
    signed_adder_tree_acc_if.slave bus
);
    localparam int L  = $clog2(NUM_IN);
    localparam int TW = IN_W + L;
    // One guard bit above the wider of accumulator and tree output, so
    // acc + tree_out is exact before fitting.
    localparam int AW = ((OUT_W > TW) ? OUT_W : TW) + 1;

    localparam logic signed [AW-1:0] MAX_V =
        $signed({{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [AW-1:0] MIN_V =
        $signed({{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

    function automatic logic out_of_range(input logic signed [AW-1:0] v);
        return (v > MAX_V) || (v < MIN_V);
    endfunction

    function automatic logic signed [OUT_W-1:0] fit(input logic signed [AW-1:0] v);
        if (SAT != 0 && v > MAX_V) return MAX_V[OUT_W-1:0];
        if (SAT != 0 && v < MIN_V) return MIN_V[OUT_W-1:0];
        return v[OUT_W-1:0];
    endfunction

    // Level k holds 2^(L-k) nodes of IN_W+k bits; level 0 is the raw input
    // padded with zero lanes up to the next power of two.
    for (genvar k = 0; k <= L; k++) begin : g_lvl
        localparam int W = IN_W + k;
        localparam int N = 1 << (L - k);

        logic signed [W-1:0] node [N];
        logic                vld;

        if (k == 0) begin : g_src
            for (genvar j = 0; j < N; j++) begin : g_lane
                if (j < NUM_IN) begin : g_used
                    assign node[j] = bus.addends[j*IN_W +: IN_W];
                end else begin : g_pad
                    assign node[j] = '0;
                end
            end
            assign vld = bus.in_valid;
        end else begin : g_reg
            logic signed [W-1:0] node_d [N];
            logic signed [W-1:0] node_q [N];
            logic                vld_d;
            logic                vld_q;

            always_comb begin
                for (int j = 0; j < N; j++) begin
                    node_d[j] = '0;
                    if (bus.enable) begin
                        node_d[j] = W'(g_lvl[k-1].node[2*j]) + W'(g_lvl[k-1].node[2*j+1]);
                    end
                end
                vld_d = bus.enable & g_lvl[k-1].vld;
            end

            // ---- tree level k register ----
            always_ff @(posedge clk) begin
                if (!resetb) begin
                    for (int j = 0; j < N; j++) node_q[j] <= '0;
                    vld_q <= 1'b0;
                end else begin
                    node_q <= node_d;
                    vld_q  <= vld_d;
                end
            end

            assign node = node_q;
            assign vld  = vld_q;
        end
    end

    logic signed [TW-1:0] tree_out;
    logic                 tree_vld;
    assign tree_out = g_lvl[L].node[0];
    assign tree_vld = g_lvl[L].vld;

    logic signed [AW-1:0]    full;
    logic signed [OUT_W-1:0] acc_d, acc_q;
    logic signed [OUT_W-1:0] sum_d, sum_q;
    logic                    ovf_d, ovf_q;
    logic                    out_valid_d, out_valid_q;

    always_comb begin
        full        = '0;
        acc_d       = acc_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        if (!bus.enable) begin
            acc_d = '0;
            sum_d = '0;
            ovf_d = 1'b0;
        end else if (tree_vld) begin
            // clear with a valid vector restarts the accumulation from it.
            if (bus.mode && !bus.clear) full = AW'(acc_q) + AW'(tree_out);
            else                        full = AW'(tree_out);
            sum_d = fit(full);
            if (bus.mode || bus.clear) acc_d = fit(full);
            ovf_d       = (ovf_q & ~bus.clear) | out_of_range(full);
            out_valid_d = 1'b1;
        end else if (bus.clear) begin
            acc_d = '0;
            sum_d = '0;
            ovf_d = 1'b0;
        end
    end

    // ---- final stage register ----
    always_ff @(posedge clk) begin
        if (!resetb) begin
            acc_q       <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    logic signed [OUT_W-1:0] dly_d [DELAY];
    logic signed [OUT_W-1:0] dly_q [DELAY];

    // Free-running shift of sum, independent of valid.
    always_comb begin
        dly_d[0] = sum_q;
        for (int i = 1; i < DELAY; i++) dly_d[i] = dly_q[i-1];
        if (!bus.enable) begin
            for (int i = 0; i < DELAY; i++) dly_d[i] = '0;
        end
    end

    // ---- sum_delay pipe registers ----
    always_ff @(posedge clk) begin
        if (!resetb) begin
            for (int i = 0; i < DELAY; i++) dly_q[i] <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.sum_delay = dly_q[DELAY-1];
    assign bus.overflow  = ovf_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_signed_adder_tree_acc.sv
// Directed bench for signed_adder_tree_acc: three instances
//   u_sat  : 8 lanes, 8-bit, 12-bit out, DELAY=1, saturating
//   u_wrap : same, wrapping
//   u_odd  : 5 lanes, DELAY=3, saturating
// Inputs change just after the falling edge, outputs are sampled there too.
module tb_signed_adder_tree_acc;
    logic clk = 1'b0;
    logic resetb;
    always #5 clk = ~clk;

    signed_adder_tree_acc_if #(.NUM_IN(8), .IN_W(8), .OUT_W(12)) a_if ();
    signed_adder_tree_acc_if #(.NUM_IN(8), .IN_W(8), .OUT_W(12)) b_if ();
    signed_adder_tree_acc_if #(.NUM_IN(5), .IN_W(8), .OUT_W(12)) c_if ();

    signed_adder_tree_acc #(.NUM_IN(8), .IN_W(8), .OUT_W(12), .DELAY(1), .SAT(1))
        u_sat (.clk(clk), .resetb(resetb), .bus(a_if));
    signed_adder_tree_acc #(.NUM_IN(8), .IN_W(8), .OUT_W(12), .DELAY(1), .SAT(0))
        u_wrap (.clk(clk), .resetb(resetb), .bus(b_if));
    signed_adder_tree_acc #(.NUM_IN(5), .IN_W(8), .OUT_W(12), .DELAY(3), .SAT(1))
        u_odd (.clk(clk), .resetb(resetb), .bus(c_if));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] split8(input int lo, input int hi);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = (i < 4) ? lo[7:0] : hi[7:0];
        return r;
    endfunction

    function automatic logic [63:0] alt8(input int ev, input int od);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = (i % 2 == 0) ? ev[7:0] : od[7:0];
        return r;
    endfunction

    // Three vectors in flight on u_sat, then either enable or resetb dropped
    // for one edge; afterwards the discarded vectors must never appear and
    // the accumulator must restart from zero.
    task automatic flush_test(input bit use_reset, input string nm);
        a_if.mode     = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.addends  = split8(127, 127);
        tick(1);
        a_if.addends  = split8(-128, -128);
        tick(1);
        a_if.addends  = alt8(5, -3);
        tick(1);
        a_if.in_valid = 1'b0;
        if (use_reset) resetb = 1'b0;
        else           a_if.enable = 1'b0;
        tick(1);
        chk({nm, "_sum"},       32'(a_if.sum), 0);
        chk({nm, "_sum_delay"}, 32'(a_if.sum_delay), 0);
        chk({nm, "_overflow"},  32'(a_if.overflow), 0);
        chk({nm, "_out_valid"}, 32'(a_if.out_valid), 0);
        resetb      = 1'b1;
        a_if.enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk({nm, "_no_stale_valid"}, 32'(a_if.out_valid), 0);
        end
        a_if.mode     = 1'b1;
        a_if.in_valid = 1'b1;
        a_if.addends  = split8(5, 5);
        tick(1);
        a_if.in_valid = 1'b0;
        tick(3);
        chk({nm, "_acc_restart"}, 32'(a_if.sum), 40);
    endtask

    initial begin
        resetb = 1'b0;
        a_if.enable = 1'b1; a_if.clear = 1'b0; a_if.mode = 1'b0; a_if.in_valid = 1'b0; a_if.addends = '0;
        b_if.enable = 1'b1; b_if.clear = 1'b0; b_if.mode = 1'b0; b_if.in_valid = 1'b0; b_if.addends = '0;
        c_if.enable = 1'b1; c_if.clear = 1'b0; c_if.mode = 1'b0; c_if.in_valid = 1'b0; c_if.addends = '0;

        // Reset held while stimulus is active.
        a_if.in_valid = 1'b1;
        a_if.addends  = split8(127, 127);
        a_if.clear    = 1'b1;
        tick(3);
        chk("rst_sum",       32'(a_if.sum), 0);
        chk("rst_sum_delay", 32'(a_if.sum_delay), 0);
        chk("rst_overflow",  32'(a_if.overflow), 0);
        chk("rst_out_valid", 32'(a_if.out_valid), 0);
        chk("rst_odd_sum",   32'(c_if.sum), 0);
        resetb        = 1'b1;
        a_if.in_valid = 1'b0;
        a_if.clear    = 1'b0;
        tick(2);

        // Latency: one all +127 vector in pass-through.
        a_if.in_valid = 1'b1;
        a_if.addends  = split8(127, 127);
        tick(1);
        a_if.in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("lat_no_valid", 32'(a_if.out_valid), 0);
            tick(1);
        end
        chk("lat_out_valid", 32'(a_if.out_valid), 1);
        chk("lat_sum",       32'(a_if.sum), 1016);
        tick(1);
        chk("lat_valid_drop", 32'(a_if.out_valid), 0);
        chk("lat_sum_delay",  32'(a_if.sum_delay), 1016);

        // Back-to-back pass-through vectors.
        a_if.in_valid = 1'b1;
        a_if.addends  = split8(-128, -128);
        tick(1);
        a_if.addends  = alt8(5, -3);
        tick(1);
        a_if.in_valid = 1'b0;
        tick(2);
        chk("neg_valid",    32'(a_if.out_valid), 1);
        chk("neg_sum",      32'(a_if.sum), -1024);
        chk("neg_overflow", 32'(a_if.overflow), 0);
        tick(1);
        chk("alt_valid", 32'(a_if.out_valid), 1);
        chk("alt_sum",   32'(a_if.sum), 8);
        tick(1);
        chk("alt_hold",      32'(a_if.sum), 8);
        chk("alt_sum_delay", 32'(a_if.sum_delay), 8);

        // Accumulate three all +127 vectors, saturating and wrapping.
        a_if.clear = 1'b1; b_if.clear = 1'b1;
        tick(1);
        a_if.clear = 1'b0; b_if.clear = 1'b0;
        a_if.mode  = 1'b1; b_if.mode  = 1'b1;
        a_if.in_valid = 1'b1; b_if.in_valid = 1'b1;
        a_if.addends  = split8(127, 127);
        b_if.addends  = split8(127, 127);
        tick(3);
        a_if.in_valid = 1'b0; b_if.in_valid = 1'b0;
        tick(1);
        chk("acc1_sat",      32'(a_if.sum), 1016);
        chk("acc1_wrap",     32'(b_if.sum), 1016);
        chk("acc1_sat_ovf",  32'(a_if.overflow), 0);
        tick(1);
        chk("acc2_sat",      32'(a_if.sum), 2032);
        chk("acc2_wrap",     32'(b_if.sum), 2032);
        chk("acc2_wrap_ovf", 32'(b_if.overflow), 0);
        tick(1);
        chk("acc3_sat",      32'(a_if.sum), 2047);
        chk("acc3_wrap",     32'(b_if.sum), -1048);
        chk("acc3_sat_ovf",  32'(a_if.overflow), 1);
        chk("acc3_wrap_ovf", 32'(b_if.overflow), 1);
        tick(1);
        chk("ovf_sticky",    32'(a_if.overflow), 1);
        chk("sat_hold",      32'(a_if.sum), 2047);
        a_if.clear = 1'b1; b_if.clear = 1'b1;
        tick(1);
        a_if.clear = 1'b0; b_if.clear = 1'b0;
        chk("clr_sat_sum",  32'(a_if.sum), 0);
        chk("clr_sat_ovf",  32'(a_if.overflow), 0);
        chk("clr_wrap_sum", 32'(b_if.sum), 0);
        chk("clr_wrap_ovf", 32'(b_if.overflow), 0);

        // Accumulator at 500, then clear coincident with a valid vector of 40.
        a_if.in_valid = 1'b1;
        a_if.addends  = split8(63, 62);
        tick(1);
        a_if.in_valid = 1'b0;
        tick(3);
        chk("acc_500", 32'(a_if.sum), 500);
        a_if.in_valid = 1'b1;
        a_if.addends  = split8(5, 5);
        tick(1);
        a_if.in_valid = 1'b0;
        tick(2);
        a_if.clear = 1'b1;
        tick(1);
        a_if.clear = 1'b0;
        chk("clr_valid_sum",   32'(a_if.sum), 40);
        chk("clr_valid_vld",   32'(a_if.out_valid), 1);
        chk("clr_valid_ovf",   32'(a_if.overflow), 0);

        flush_test(1'b0, "en_drop");
        flush_test(1'b1, "rst_drop");

        // Five lanes: padding to eight, latency 4, delay pipe of 3.
        for (int i = 0; i < 5; i++) c_if.addends[i*8 +: 8] = 8'(i + 1);
        c_if.in_valid = 1'b1;
        tick(1);
        c_if.in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("odd_no_valid", 32'(c_if.out_valid), 0);
            tick(1);
        end
        chk("odd_out_valid", 32'(c_if.out_valid), 1);
        chk("odd_sum",       32'(c_if.sum), 15);
        chk("odd_dly_e4",    32'(c_if.sum_delay), 0);
        tick(2);
        chk("odd_dly_e6",    32'(c_if.sum_delay), 0);
        tick(1);
        chk("odd_dly_e7",    32'(c_if.sum_delay), 15);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/signed_adder_tree_acc.md
Name: signed_adder_tree_acc

Overview:
Parametrised successor to the single-pair gradient-sum adder. Reduces NUM_IN signed addends per cycle through a registered binary adder tree. The reduced value either passes straight through or accumulates across vectors, with saturating or wrapping output arithmetic. The block also provides a valid pipeline, a sticky overflow flag and a configurable-depth delayed copy of the sum; it feeds the gradient/spin-update datapath.

Parameters:
NUM_IN, 8, number of signed addends per vector (>=2; non-power-of-2 allowed)
IN_W, 8, width of each addend, two's complement
OUT_W, 12, width of sum/sum_delay (>= IN_W)
DELAY, 1, depth of sum_delay pipe in enabled cycles (>=1)
SAT, 1, 1 = saturate final stage to OUT_W, 0 = two's-complement wrap

Ports:
clk  input  1  clock, all state updates on rising edge
resetb  input  1  synchronous active-low reset
enable  input  1  1 = run; 0 = synchronously zero all state on next edge
clear  input  1  zero accumulator and overflow flag
mode  input  1  0 = pass-through sum, 1 = accumulate
in_valid  input  1  addends valid this cycle
addends  input  NUM_IN*IN_W  packed signed addends, lane i at [i*IN_W +: IN_W]
out_valid  output  1  sum updated this cycle
sum  output  OUT_W  signed result
sum_delay  output  OUT_W  sum delayed DELAY enabled cycles
overflow  output  1  sticky: final stage clipped/wrapped since last clear

Behaviour:
- Reset (resetb=0 at edge): all tree registers, valid pipe, accumulator, sum, sum_delay, delay pipe, overflow, out_valid = 0. Reset has priority over enable, clear and in_valid.
- enable=0 (resetb=1): same zeroing as reset on that edge; in-flight vectors are discarded, not resumed.
- Tree: L = ceil(log2(NUM_IN)) registered levels. Missing lanes are padded with 0. Level k width = IN_W+k, so there is no internal overflow. A valid bit travels alongside every level.
- Final stage, one register after the tree. Latency in_valid -> out_valid = L+1 cycles; a new vector is accepted every cycle.
- mode=0, tree valid: sum <= fit(tree_out).
- mode=1, tree valid: acc <= fit(acc + tree_out), computed at full width before fitting; sum = acc.
- mode is sampled at the final stage in the same cycle as the tree valid.
- Tree not valid: sum and acc hold; out_valid=0.
- fit(): SAT=1 clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; SAT=0 truncates to OUT_W LSBs. overflow is set when the full-width value is out of range (both SAT settings) and stays set until clear, enable=0 or reset.
- clear=1 without tree valid: acc=0, sum=0, overflow=0.
- clear=1 with tree valid: accumulator loads fit(tree_out), i.e. a fresh start including this vector. overflow = out-of-range status of this vector only.
- sum_delay: shift pipe of DELAY registers, advancing every enabled cycle regardless of valid. It mirrors sum DELAY cycles later.
- mode change without clear is legal: the accumulator continues from its held value.

Test Plan:
- Reset, then params 8/8/12/1/1, any stimulus -> sum=sum_delay=0, overflow=0, out_valid=0. One vector all +127, mode=0 -> out_valid at cycle +4, sum=1016; sum_delay=1016 one cycle later.
- mode=0, all lanes -128 -> sum=-1024, overflow=0. Then lanes alternating +5/-3 -> sum=8. Back-to-back vectors give back-to-back out_valid.
- mode=1, SAT=1, three vectors of all +127 -> sum 1016, 2032, 2047; overflow=1 after the third. clear -> sum=0, overflow=0.
- Same as above with SAT=0 -> sum 1016, 2032, -1048; overflow=1.
- mode=1, acc=500, then clear asserted together with tree valid for a vector summing to 40 -> sum=40 (not 540).
- Mid-stream enable=0 for one cycle with 3 vectors in flight -> all outputs 0 the next cycle and no out_valid for discarded vectors. Repeat with resetb=0 -> same.
- NUM_IN=5: lanes 1,2,3,4,5 -> sum=15, latency L+1=4 cycles.
